// File: rtl/tx_pkg.sv
// Shared constants and FSM state type for the rx->tx piece transmit path.
package tx_pkg;

    localparam int unsigned SLOTS   = 8;
    localparam int unsigned PIECE_W = 10;
    localparam int unsigned SLOT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tx_slot_pick.sv
// Lowest-set-slot finder over the pending mask, plus any-set and exactly-one flags.
module tx_slot_pick
    import tx_pkg::*;
#(
    parameter int unsigned SLOTS  = tx_pkg::SLOTS,
    parameter int unsigned SLOT_W = tx_pkg::SLOT_W
) (
    input  logic [SLOTS-1:0]  pend_i,
    output logic [SLOT_W-1:0] idx_o,
    output logic              any_o,
    output logic              one_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (pend_i[i] && !found) begin
                idx_o = SLOT_W'(i);
                found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a one-hot mask.
    assign any_o = |pend_i;
    assign one_o = any_o && ((pend_i & (pend_i - SLOTS'(1))) == '0);

endmodule

// File: rtl/tx.sv
// Captures one frame of pieces from rx and serializes the occupied slots in
// ascending order over a valid/ack handshake, ending with tx_last and tx_done.
module tx
    import tx_pkg::*;
#(
    parameter int unsigned SLOTS   = tx_pkg::SLOTS,
    parameter int unsigned PIECE_W = tx_pkg::PIECE_W,
    parameter int unsigned SLOT_W  = tx_pkg::SLOT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SLOTS*PIECE_W-1:0] rx_tx_pcs,
    input  logic [SLOTS-1:0]         rx_tx_valid,
    input  logic                     load,
    output logic                     tx_ready,
    output logic [PIECE_W-1:0]       tx_piece,
    output logic [SLOT_W-1:0]        tx_slot,
    output logic                     tx_valid,
    output logic                     tx_last,
    input  logic                     tx_ack,
    output logic                     tx_done
);

    state_e                   state_q, state_d;
    logic [SLOTS*PIECE_W-1:0] pcs_q, pcs_d;
    logic [SLOTS-1:0]         pend_q, pend_d;

    logic [SLOT_W-1:0]        pick_idx;
    logic                     pick_any;
    logic                     pick_one;

    tx_slot_pick #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_pick (
        .pend_i (pend_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any),
        .one_o  (pick_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pcs_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pcs_q   <= pcs_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcs_d   = pcs_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    pcs_d   = rx_tx_pcs;
                    pend_d  = rx_tx_valid;
                    state_d = (|rx_tx_valid) ? SEND : DONE;
                end
            end
            SEND: begin
                if (tx_ack) begin
                    pend_d = pend_q & ~(SLOTS'(1) << pick_idx);
                    if (pick_one || !pick_any) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                pend_d  = '0;
                state_d = IDLE;
            end
            default: begin
                pend_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state; data outputs read zero outside SEND.
    assign tx_ready = (state_q == IDLE);
    assign tx_valid = (state_q == SEND);
    assign tx_done  = (state_q == DONE);
    assign tx_last  = tx_valid && pick_one;
    assign tx_slot  = tx_valid ? pick_idx : '0;
    assign tx_piece = tx_valid ? pcs_q[32'(pick_idx)*PIECE_W +: PIECE_W] : '0;

endmodule

// File: tb/tb_tx.sv
// Directed vector table, hand sequences for stall/load-injection/reset, and a
// randomized scoreboard run for the tx piece serializer.
module tb_tx;

    localparam int unsigned SLOTS   = 8;
    localparam int unsigned PIECE_W = 10;
    localparam int unsigned SLOT_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [SLOTS*PIECE_W-1:0] rx_tx_pcs = '0;
    logic [SLOTS-1:0]         rx_tx_valid = '0;
    logic                     load = 1'b0;
    logic                     tx_ready;
    logic [PIECE_W-1:0]       tx_piece;
    logic [SLOT_W-1:0]        tx_slot;
    logic                     tx_valid;
    logic                     tx_last;
    logic                     tx_ack = 1'b0;
    logic                     tx_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned exp_slot [8];
    int unsigned exp_cnt;

    tx dut (
        .clk         (clk),
        .rst         (rst),
        .rx_tx_pcs   (rx_tx_pcs),
        .rx_tx_valid (rx_tx_valid),
        .load        (load),
        .tx_ready    (tx_ready),
        .tx_piece    (tx_piece),
        .tx_slot     (tx_slot),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ack      (tx_ack),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mask;
        logic [9:0]  base;
        int unsigned cnt;
        int unsigned slots [8];
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [SLOTS*PIECE_W-1:0] mk_pcs(input logic [9:0] base);
        logic [SLOTS*PIECE_W-1:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) p[k*10 +: 10] = base + 10'(k);
        return p;
    endfunction

    // ack_mode: 0 = held high, 1 = random, 2 = stall stall_n cycles on stall_slot
    task automatic run_frame(input logic [7:0] mask, input logic [SLOTS*PIECE_W-1:0] pcs,
                             input int ack_mode, input int unsigned stall_slot,
                             input int unsigned stall_n, input bit inject);
        int unsigned beats, stalls, held;
        bit done_seen;
        logic a;
        logic [9:0] piece_req;
        beats = 0; stalls = 0; held = 0; done_seen = 0;
        @(negedge clk);
        chk("ready_before_load", tx_ready, 1);
        rx_tx_pcs   = pcs;
        rx_tx_valid = mask;
        load        = 1'b1;
        tx_ack      = 1'b0;
        for (int cyc = 1; cyc <= 80 && !done_seen; cyc++) begin
            @(negedge clk);
            load      = 1'b0;
            rx_tx_pcs = ~pcs;
            if (inject && cyc == 3) begin
                load        = 1'b1;
                rx_tx_valid = 8'h01;
            end
            if (tx_done) begin
                chk("done_beats", beats, exp_cnt);
                chk("done_cycle", cyc, exp_cnt + 1 + stalls);
                chk("done_valid_low", tx_valid, 0);
                done_seen = 1;
                tx_ack = 1'b0;
            end else if (tx_valid) begin
                if (beats >= exp_cnt) begin
                    chk("extra_beat", beats, exp_cnt - 1);
                    a = 1'b1;
                end else begin
                    piece_req = pcs[exp_slot[beats]*10 +: 10];
                    chk("beat_slot", tx_slot, exp_slot[beats]);
                    chk("beat_piece", tx_piece, piece_req);
                    chk("beat_last", tx_last, (beats == exp_cnt - 1) ? 1 : 0);
                    chk("beat_ready_low", tx_ready, 0);
                    if (ack_mode == 1) a = 1'($urandom_range(0, 1));
                    else if (ack_mode == 2 && exp_slot[beats] == stall_slot && held < stall_n) begin
                        a = 1'b0;
                        held++;
                    end else a = 1'b1;
                end
                if (a) beats++; else stalls++;
                tx_ack = a;
            end else begin
                chk("gap_valid", tx_valid, 1);
                tx_ack = (ack_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!done_seen) chk("timeout_no_done", 0, 1);
        load   = 1'b0;
        tx_ack = 1'b0;
        @(negedge clk);
        chk("ready_after_done", tx_ready, 1);
        chk("done_single_pulse", tx_done, 0);
        chk("valid_after_done", tx_valid, 0);
    endtask

    task automatic model_expect(input logic [7:0] mask);
        exp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            exp_slot[k] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
                exp_slot[exp_cnt] = k;
                exp_cnt++;
            end
        end
    endtask

    initial begin
        vec_t vecs [7];
        logic [SLOTS*PIECE_W-1:0] rp;
        logic [7:0] rm;

        vecs[0] = '{mask: 8'h85, base: 10'h000, cnt: 3, slots: '{0, 2, 7, 0, 0, 0, 0, 0}};
        vecs[1] = '{mask: 8'h01, base: 10'h120, cnt: 1, slots: '{0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{mask: 8'h80, base: 10'h3F0, cnt: 1, slots: '{7, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{mask: 8'hAA, base: 10'h055, cnt: 4, slots: '{1, 3, 5, 7, 0, 0, 0, 0}};
        vecs[4] = '{mask: 8'h3C, base: 10'h200, cnt: 4, slots: '{2, 3, 4, 5, 0, 0, 0, 0}};
        vecs[5] = '{mask: 8'hFF, base: 10'h010, cnt: 8, slots: '{0, 1, 2, 3, 4, 5, 6, 7}};
        vecs[6] = '{mask: 8'h00, base: 10'h0AA, cnt: 0, slots: '{0, 0, 0, 0, 0, 0, 0, 0}};

        // reset values while reset is held
        @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_valid", tx_valid, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_piece", tx_piece, 0);
        chk("rst_slot", tx_slot, 0);
        @(negedge clk);
        rst = 1'b0;

        // table vectors, ack tied high
        for (int v = 0; v < 7; v++) begin
            exp_cnt = vecs[v].cnt;
            for (int k = 0; k < 8; k++) exp_slot[k] = vecs[v].slots[k];
            run_frame(vecs[v].mask, mk_pcs(vecs[v].base), 0, 0, 0, 1'b0);
        end

        // full frame, 3-cycle stall on slot 3, load pulse with new data mid-frame
        exp_cnt = 8;
        for (int k = 0; k < 8; k++) exp_slot[k] = k;
        run_frame(8'hFF, mk_pcs(10'h000), 2, 3, 3, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_second_frame_valid", tx_valid, 0);
            chk("no_second_frame_done", tx_done, 0);
        end

        // reset during the second beat of a 4-piece frame
        @(negedge clk);
        rx_tx_pcs = mk_pcs(10'h100); rx_tx_valid = 8'h0F; load = 1'b1; tx_ack = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pre_rst_slot0", tx_slot, 0);
        @(negedge clk);
        chk("pre_rst_slot1", tx_slot, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", tx_valid, 0);
        chk("async_rst_ready", tx_ready, 1);
        chk("async_rst_piece", tx_piece, 0);
        chk("async_rst_slot", tx_slot, 0);
        chk("async_rst_last", tx_last, 0);
        @(negedge clk);
        rst = 1'b0; tx_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", tx_done, 0);
            chk("post_rst_no_valid", tx_valid, 0);
        end
        exp_cnt = 4;
        for (int k = 0; k < 8; k++) exp_slot[k] = (k < 4) ? k : 0;
        run_frame(8'h0F, mk_pcs(10'h300), 0, 0, 0, 1'b0);

        // randomized frames against the ascending-slot model
        for (int f = 0; f < 1000; f++) begin
            rm = 8'($urandom);
            for (int k = 0; k < 8; k++) rp[k*10 +: 10] = 10'($urandom);
            model_expect(rm);
            run_frame(rm, rp, 1, 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
